// File: rtl/mtx_pkg.sv
// Shared constants and types for the MTX I/Q framer.
package mtx_pkg;
  localparam int MTX_IQ_W   = 16;
  localparam int MTX_GAIN_W = 16;
  localparam int MTX_SPP_W  = 16;
  localparam int MTX_PKT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SYNC,
    ST_RUN,
    ST_FLUSH
  } mtx_state_e;

  // Half an output LSB for a Q1.(gw-1) gain, added before the arithmetic shift.
  function automatic longint mtx_rnd(input int gw);
    return longint'(1) << (gw - 2);
  endfunction
endpackage

// File: rtl/mtx_gain_sat.sv
// One I/Q component: registered signed product, then round-half-up and saturate.
module mtx_gain_sat
  import mtx_pkg::*;
#(
  parameter int X_W = MTX_IQ_W,
  parameter int G_W = MTX_GAIN_W
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           ld,
  input  logic [X_W-1:0] x,
  input  logic [G_W-1:0] g,
  output logic [X_W-1:0] y
);
  // One guard bit so the rounding add can never wrap the product.
  localparam int PW = X_W + G_W + 1;
  localparam int RW = PW - (G_W - 1);
  localparam logic signed [PW-1:0] RND  = PW'(mtx_rnd(G_W));
  localparam logic signed [RW-1:0] MAXV = {{(RW-X_W+1){1'b0}}, {(X_W-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-X_W+1){1'b1}}, {(X_W-1){1'b0}}};

  logic signed [PW-1:0] prod_q, prod_d, sum;
  logic signed [RW-1:0] r;

  always_comb begin
    prod_d = prod_q;
    if (ld)
      prod_d = $signed({{(PW-X_W){x[X_W-1]}}, x}) * $signed({{(PW-G_W){g[G_W-1]}}, g});
    sum = prod_q + RND;
    r   = RW'(sum >>> (G_W - 1));
    if (r > MAXV)      y = MAXV[X_W-1:0];
    else if (r < MINV) y = MINV[X_W-1:0];
    else               y = r[X_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (clr) prod_q <= '0;
    else     prod_q <= prod_d;
  end
endmodule

// File: rtl/mtx_iq_framer.sv
// Gains, rounds and frames the DDS sin/cos stream into SPP-sample packets,
// with bursts gated by start/stop and aligned to the generator sync boundary.
module mtx_iq_framer
  import mtx_pkg::*;
#(
  parameter int SIN_COS_WIDTH = MTX_IQ_W,
  parameter int GAIN_WIDTH    = MTX_GAIN_W,
  parameter int SPP_WIDTH     = MTX_SPP_W,
  parameter int PKT_CNT_WIDTH = MTX_PKT_W,
  parameter int SPP           = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       srst,
  input  logic                       start,
  input  logic                       stop,
  input  logic [GAIN_WIDTH-1:0]      gain,
  input  logic                       sync_ready,
  input  logic [2*SIN_COS_WIDTH-1:0] in_tdata,
  input  logic                       in_tvalid,
  input  logic                       in_tlast,
  output logic                       in_tready,
  output logic [2*SIN_COS_WIDTH-1:0] out_tdata,
  output logic                       out_tvalid,
  output logic                       out_tlast,
  input  logic                       out_tready,
  output logic                       busy,
  output logic [PKT_CNT_WIDTH-1:0]   pkt_count,
  output logic [SPP_WIDTH-1:0]       samp_idx
);
  localparam int W      = SIN_COS_WIDTH;
  localparam int STAGES = 2;
  localparam logic [SPP_WIDTH-1:0] LAST_IDX = SPP_WIDTH'(SPP - 1);

  mtx_state_e                state_q, state_d;
  logic [SPP_WIDTH-1:0]      samp_idx_q, samp_idx_d;
  logic [PKT_CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;
  logic [GAIN_WIDTH-1:0]     gain_q, gain_d, gain_eff;
  logic [STAGES:1]           vld_pipe_q, vld_pipe_d;
  logic                      s1_last_q, s1_last_d, s2_last_q, s2_last_d;
  logic [2*W-1:0]            s2_data_q, s2_data_d;
  logic [W-1:0]              q_y, i_y;
  logic                      clr, s2_ld, s1_adv, acc, is_last, unused_tlast;

  assign clr          = reset | srst;
  assign unused_tlast = in_tlast;
  assign is_last      = (samp_idx_q == LAST_IDX);
  assign s2_ld        = vld_pipe_q[1] & (~vld_pipe_q[2] | out_tready);
  assign s1_adv       = ~vld_pipe_q[1] | s2_ld;
  // First sample of a packet multiplies by the live gain, which is latched as it goes in.
  assign gain_eff     = (samp_idx_q == '0) ? gain : gain_q;

  always_comb begin
    state_d   = state_q;
    acc       = 1'b0;
    in_tready = s1_adv;
    case (state_q)
      ST_IDLE: begin
        in_tready = 1'b1;
        if (start) state_d = ST_WAIT_SYNC;
      end
      ST_WAIT_SYNC: begin
        acc = in_tvalid & sync_ready & s1_adv & ~stop;
        if (stop)     state_d = ST_IDLE;
        else if (acc) state_d = ST_RUN;
      end
      ST_RUN: begin
        acc = in_tvalid & s1_adv;
        if (stop) state_d = (acc & is_last) ? ST_IDLE : ST_FLUSH;
      end
      ST_FLUSH: begin
        acc = in_tvalid & s1_adv;
        if (acc & is_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    samp_idx_d  = samp_idx_q;
    pkt_count_d = pkt_count_q;
    gain_d      = gain_q;
    vld_pipe_d  = vld_pipe_q;
    s1_last_d   = s1_last_q;
    s2_last_d   = s2_last_q;
    s2_data_d   = s2_data_q;
    if (acc) begin
      samp_idx_d = is_last ? '0 : samp_idx_q + SPP_WIDTH'(1);
      s1_last_d  = is_last;
      if (is_last) pkt_count_d = pkt_count_q + PKT_CNT_WIDTH'(1);
      if (samp_idx_q == '0) gain_d = gain;
    end
    if (s1_adv) vld_pipe_d[1] = acc;
    if (s2_ld) begin
      vld_pipe_d[2] = 1'b1;
      s2_data_d     = {q_y, i_y};
      s2_last_d     = s1_last_q;
    end else if (out_tready) begin
      vld_pipe_d[2] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      samp_idx_q  <= '0;
      pkt_count_q <= '0;
      gain_q      <= '0;
      vld_pipe_q  <= '0;
      s1_last_q   <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      samp_idx_q  <= samp_idx_d;
      pkt_count_q <= pkt_count_d;
      gain_q      <= gain_d;
      vld_pipe_q  <= vld_pipe_d;
      s1_last_q   <= s1_last_d;
      s2_last_q   <= s2_last_d;
      s2_data_q   <= s2_data_d;
    end
  end

  mtx_gain_sat #(.X_W(W), .G_W(GAIN_WIDTH)) u_q (
    .clk(clk), .clr(clr), .ld(acc), .x(in_tdata[2*W-1:W]), .g(gain_eff), .y(q_y)
  );
  mtx_gain_sat #(.X_W(W), .G_W(GAIN_WIDTH)) u_i (
    .clk(clk), .clr(clr), .ld(acc), .x(in_tdata[W-1:0]), .g(gain_eff), .y(i_y)
  );

  assign out_tdata  = s2_data_q;
  assign out_tvalid = vld_pipe_q[2];
  assign out_tlast  = s2_last_q;
  assign busy       = (state_q != ST_IDLE);
  assign pkt_count  = pkt_count_q;
  assign samp_idx   = samp_idx_q;
endmodule
